// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory serving multicycle CPU requests.
// Each request completes with a one-cycle MemReady pulse after WAIT_CYCLES
// wait states. Misaligned or out-of-range addresses complete after one
// cycle with AddrErr set and never touch the array.
module mem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] MemData,
    output logic        MemReady,
    output logic        AddrErr,
    output logic        Busy
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_op_wr;
    logic                   r_err;
    logic [ADDR_BITS-1:0]   r_idx;
    logic [31:0]            r_wdata;
    logic [31:0]            r_mem_data;
    logic                   r_ready;
    logic                   r_addr_err;
    logic                   r_busy;
    logic [31:0]            r_mem [DEPTH];

    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_err_nxt;
    logic                   w_latch;
    logic                   w_req;
    logic                   w_addr_err;
    logic                   w_do_access;
    logic                   w_acc_write;
    logic [ADDR_BITS-1:0]   w_acc_idx;
    logic [31:0]            w_acc_data;

    assign w_req      = MemRead | MemWrite;
    // Any bit above the stored word range, or a non-word-aligned byte offset.
    assign w_addr_err = (Address[1:0] != 2'b00) ||
                        ((Address >> (ADDR_BITS + 2)) != 32'd0);

    // Next-state, counter and access-strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_latch     = 1'b0;
        w_do_access = 1'b0;
        w_acc_write = r_op_wr;
        w_acc_idx   = r_idx;
        w_acc_data  = r_wdata;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    // Write wins when both request lines are high.
                    w_latch     = 1'b1;
                    w_err_nxt   = w_addr_err;
                    w_acc_write = MemWrite;
                    w_acc_idx   = Address[ADDR_BITS+1:2];
                    w_acc_data  = WriteData;
                    if (w_addr_err) begin
                        w_state_nxt = ST_RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        w_do_access = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_cnt_nxt   = CNT_LOAD;
                        w_state_nxt = ST_WAIT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt != {CNT_W{1'b0}}) begin
                    w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    w_do_access = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counter, request latches and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_err      <= 1'b0;
            r_op_wr    <= 1'b0;
            r_idx      <= {ADDR_BITS{1'b0}};
            r_wdata    <= 32'd0;
            r_mem_data <= 32'd0;
            r_ready    <= 1'b0;
            r_addr_err <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err      <= w_err_nxt;
            r_ready    <= (w_state_nxt == ST_RESP);
            r_addr_err <= (w_state_nxt == ST_RESP) && w_err_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            if (w_latch) begin
                r_op_wr <= MemWrite;
                r_idx   <= Address[ADDR_BITS+1:2];
                r_wdata <= WriteData;
            end
            // Only successful reads refresh the data register.
            if (w_do_access && !w_acc_write) begin
                r_mem_data <= r_mem[w_acc_idx];
            end
        end
    end

    // Storage array write port; never cleared, and a reset edge blocks a commit.
    always_ff @(posedge Clk) begin
        if (!Reset && w_do_access && w_acc_write) begin
            r_mem[w_acc_idx] <= w_acc_data;
        end
    end

    assign MemData  = r_mem_data;
    assign MemReady = r_ready;
    assign AddrErr  = r_addr_err;
    assign Busy     = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, hand-written
// multi-cycle sequences and randomized requests against a reference model.
// Instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0.
module tb_mem_responder;

    localparam int W0 = 2;
    localparam int W1 = 0;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        mem_read  [2];
    logic        mem_write [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic [31:0] md        [2];
    logic        rdy       [2];
    logic        aerr      [2];
    logic        busy      [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: stored words, which words are known, expected MemData.
    logic [31:0] mdl_mem [2][256];
    logic        mdl_vld [2][256];
    logic [31:0] exp_md  [2];
    logic        exp_ok  [2];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_md;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(W0)) dut (
        .Clk(clk), .Reset(rst[0]), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
        .Address(addr[0]), .WriteData(wdata[0]), .MemData(md[0]),
        .MemReady(rdy[0]), .AddrErr(aerr[0]), .Busy(busy[0])
    );

    mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(W1)) dut0 (
        .Clk(clk), .Reset(rst[1]), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
        .Address(addr[1]), .WriteData(wdata[1]), .MemData(md[1]),
        .MemReady(rdy[1]), .AddrErr(aerr[1]), .Busy(busy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model of one request: returns expected latency, error and MemData.
    function automatic void ref_apply(input int s, input logic r, input logic w,
                                      input logic [31:0] a, input logic [31:0] d,
                                      output int lat, output logic err,
                                      output logic [31:0] m, output logic ok);
        err = (a[1:0] != 2'b00) || (a >= 32'h0000_0400);
        lat = err ? 1 : (((s == 0) ? W0 : W1) + 1);
        if (!err && w) begin
            mdl_mem[s][a[9:2]] = d;
            mdl_vld[s][a[9:2]] = 1'b1;
        end else if (!err && r) begin
            exp_md[s] = mdl_mem[s][a[9:2]];
            exp_ok[s] = mdl_vld[s][a[9:2]];
        end
        m  = exp_md[s];
        ok = exp_ok[s];
    endfunction

    // Issue one request at a negedge, wait for MemReady (bounded), then drop it.
    task automatic run_req(input int s, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic e, output logic [31:0] m);
        lat = 0;
        e   = 1'bx;
        m   = 32'hx;
        mem_read[s]  = r;
        mem_write[s] = w;
        addr[s]      = a;
        wdata[s]     = d;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            check("busy_active", {31'd0, busy[s]}, 32'd1);
            if (rdy[s]) begin
                lat = c;
                e   = aerr[s];
                m   = md[s];
            end
        end
        mem_read[s]  = 1'b0;
        mem_write[s] = 1'b0;
        if (lat == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got no MemReady expected one within 20 cycles");
        end
        @(negedge clk);
        check("ready_pulse_end", {31'd0, rdy[s]}, 32'd0);
        check("busy_idle", {31'd0, busy[s]}, 32'd0);
    endtask

    task automatic do_checked(input int s, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d);
        int          lat, elat;
        logic        e, ee, ok;
        logic [31:0] m, em;
        ref_apply(s, r, w, a, d, elat, ee, em, ok);
        run_req(s, r, w, a, d, lat, e, m);
        check("latency", lat, elat);
        check("addr_err", {31'd0, e}, {31'd0, ee});
        if (ok) check("mem_data", m, em);
    endtask

    initial begin
        int          lat, elat;
        logic        e, ee, ok;
        logic [31:0] m, em, a;
        int          k, op;

        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; mem_read[s] = 1'b0; mem_write[s] = 1'b0;
            addr[s] = 32'd0; wdata[s] = 32'd0;
            exp_md[s] = 32'd0; exp_ok[s] = 1'b1;
            for (int i = 0; i < 256; i++) begin
                mdl_mem[s][i] = 32'd0;
                mdl_vld[s][i] = 1'b0;
            end
        end

        tbl[0]  = '{1'b0, 1'b1, 32'h000, 32'hA5A5_0000, 1'b0, 3, 32'h0000_0000};
        tbl[1]  = '{1'b0, 1'b1, 32'h010, 32'hDEAD_BEEF, 1'b0, 3, 32'h0000_0000};
        tbl[2]  = '{1'b1, 1'b0, 32'h010, 32'h0,         1'b0, 3, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b1, 1'b0, 32'h012, 32'h0,         1'b1, 1, 32'hDEAD_BEEF};
        tbl[4]  = '{1'b0, 1'b1, 32'h400, 32'hCAFE_F00D, 1'b1, 1, 32'hDEAD_BEEF};
        tbl[5]  = '{1'b1, 1'b0, 32'h000, 32'h0,         1'b0, 3, 32'hA5A5_0000};
        tbl[6]  = '{1'b1, 1'b1, 32'h020, 32'h1234_5678, 1'b0, 3, 32'hA5A5_0000};
        tbl[7]  = '{1'b1, 1'b0, 32'h020, 32'h0,         1'b0, 3, 32'h1234_5678};
        tbl[8]  = '{1'b0, 1'b1, 32'h3FC, 32'h0BAD_F00D, 1'b0, 3, 32'h1234_5678};
        tbl[9]  = '{1'b1, 1'b0, 32'h3FC, 32'h0,         1'b0, 3, 32'h0BAD_F00D};
        tbl[10] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,   1'b1, 1, 32'h0BAD_F00D};
        tbl[11] = '{1'b0, 1'b1, 32'h030, 32'h1111_1111, 1'b0, 3, 32'h0BAD_F00D};

        // Reset values
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_mem_data", md[s], 32'd0);
            check("rst_ready", {31'd0, rdy[s]}, 32'd0);
            check("rst_addr_err", {31'd0, aerr[s]}, 32'd0);
            check("rst_busy", {31'd0, busy[s]}, 32'd0);
            rst[s] = 1'b0;
        end
        @(negedge clk);

        // Directed table on the two-wait-state instance
        for (int i = 0; i < 12; i++) begin
            ref_apply(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, elat, ee, em, ok);
            run_req(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, lat, e, m);
            check("tbl_latency", lat, tbl[i].exp_lat);
            check("tbl_addr_err", {31'd0, e}, {31'd0, tbl[i].exp_err});
            check("tbl_mem_data", m, tbl[i].exp_md);
        end

        // Reset while a write to 0x030 is still waiting: write must be lost
        mem_write[0] = 1'b1; addr[0] = 32'h030; wdata[0] = 32'h55AA_55AA;
        @(negedge clk);
        check("rstmid_busy_wait", {31'd0, busy[0]}, 32'd1);
        rst[0] = 1'b1; mem_write[0] = 1'b0;
        @(negedge clk);
        check("rstmid_ready", {31'd0, rdy[0]}, 32'd0);
        check("rstmid_busy", {31'd0, busy[0]}, 32'd0);
        check("rstmid_mem_data", md[0], 32'd0);
        rst[0] = 1'b0;
        exp_md[0] = 32'd0; exp_ok[0] = 1'b1;
        @(negedge clk);
        do_checked(0, 1'b1, 1'b0, 32'h030, 32'd0);
        check("rstmid_old_data", md[0], 32'h1111_1111);

        // Held read on 0x010: pulses in cycles 3 and 7
        mem_read[0] = 1'b1; addr[0] = 32'h010;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("held_ready_w2", {31'd0, rdy[0]}, (c == 3 || c == 7) ? 32'd1 : 32'd0);
            if (c == 3 || c == 7) check("held_data_w2", md[0], 32'hDEAD_BEEF);
        end
        mem_read[0] = 1'b0;
        exp_md[0] = 32'hDEAD_BEEF; exp_ok[0] = 1'b1;
        @(negedge clk);

        // Zero-wait instance: write, then held read pulses in cycles 1, 3, 5
        do_checked(1, 1'b0, 1'b1, 32'h010, 32'hDEAD_BEEF);
        mem_read[1] = 1'b1; addr[1] = 32'h010;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("held_ready_w0", {31'd0, rdy[1]}, (c % 2 == 1) ? 32'd1 : 32'd0);
            if (c % 2 == 1) check("held_data_w0", md[1], 32'hDEAD_BEEF);
        end
        mem_read[1] = 1'b0;
        exp_md[1] = 32'hDEAD_BEEF; exp_ok[1] = 1'b1;
        @(negedge clk);

        // Randomized requests on both instances
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 150; n++) begin
                k  = $urandom_range(0, 9);
                op = $urandom_range(0, 3);
                a  = 32'($urandom_range(0, 15)) << 2;
                if (k == 7) a = a | 32'($urandom_range(1, 3));
                else if (k >= 8) a = ($urandom() & 32'hFFFF_FFFC) | 32'h0000_0400;
                do_checked(s, (op == 0 || op >= 2) ? 1'b1 : 1'b0,
                              (op == 1 || op == 3) ? 1'b1 : 1'b0, a, $urandom());
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed data/instruction memory that services the multicycle CPU's memory requests (MemRead/MemWrite, Address, WriteData).
- Returns MemData with a MemReady completion pulse after a configurable number of wait states.
- Flags misaligned or out-of-range accesses.
- Sits between the CPU datapath address mux (PC or ALUOut) and the IR/MDR load path.

Parameters:
- ADDR_BITS, 8, log2 of the number of 32-bit words stored (default 256 words, byte range 0x000-0x3FF).
- WAIT_CYCLES, 2, wait states inserted before an in-range access completes (0 allowed).

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- MemRead  in  1  read request, level-sensitive.
- MemWrite  in  1  write request, level-sensitive.
- Address  in  32  byte address.
- WriteData  in  32  write data.
- MemData  out  32  read data, registered.
- MemReady  out  1  one-cycle completion pulse.
- AddrErr  out  1  error qualifier, valid only while MemReady=1.
- Busy  out  1  high while a request is being serviced (any state other than IDLE).

Behaviour:
- All outputs are registered.
- Reset values: MemData=0, MemReady=0, AddrErr=0, Busy=0, state=IDLE, wait counter=0. The storage array is not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If MemRead or MemWrite is high: latch Address, WriteData and op. If both are high, the op is a write and the read is ignored.
  - Error check (error if either holds): Address[1:0]!=0, or Address[31:ADDR_BITS+2]!=0.
  - Error -> RESP immediately, no array access, no wait states.
  - In range, WAIT_CYCLES=0 -> perform the access on this edge, go to RESP.
  - In range, WAIT_CYCLES>0 -> go to WAIT, load counter with WAIT_CYCLES-1.
- WAIT:
  - Counter !=0 -> decrement it.
  - Counter ==0 -> perform the access on this edge, go to RESP.
  - Request inputs are ignored while in WAIT; latched values are used.
- Access:
  - Write: array[Address[ADDR_BITS+1:2]] <= WriteData.
  - Read: MemData <= array[index].
  - Only one access per request.
- RESP:
  - MemReady=1 for exactly one cycle. AddrErr=1 if the request errored, else 0.
  - Next state is IDLE unconditionally; no request is accepted in the RESP cycle.
- Latency: request sampled in cycle 0 (IDLE).
  - In-range: MemReady in cycle WAIT_CYCLES+1.
  - Errored: MemReady in cycle 1.
- MemData after completion:
  - Holds its value until the next successful read.
  - Is unchanged by writes and by errored reads.
- Requester protocol: hold the request until MemReady, then deassert. A request still high in the cycle after RESP is a new request.
- Busy: 1 in WAIT and RESP, 0 in IDLE.
- Reset mid-operation (WAIT or RESP):
  - Abort and go to IDLE with reset output values.
  - A write not yet committed is discarded. A committed write stays.
- Reset has priority over all other events in the same cycle.

Test Plan (ADDR_BITS=8, WAIT_CYCLES=2 unless stated):
- Write 0xDEADBEEF to 0x010, then read 0x010:
  - Each MemReady pulses in cycle 3 after acceptance with AddrErr=0.
  - Read returns MemData=0xDEADBEEF.
  - Busy high in cycles 1-3.
- Misaligned read at 0x012 -> MemReady=1 and AddrErr=1 in cycle 1; MemData keeps its previous value (0xDEADBEEF).
- Out-of-range write of 0xCAFEF00D to 0x400 -> AddrErr in cycle 1. A read of 0x000 then returns its prior contents, confirming no aliasing.
- MemRead and MemWrite both high, address 0x020, data 0x12345678 -> treated as a write; a following read of 0x020 returns 0x12345678.
- Write 0x11111111 to 0x030. Then start a write of 0x55AA55AA to 0x030 and assert Reset in cycle 1 (WAIT):
  - Next cycle: MemReady=0, Busy=0, MemData=0.
  - A read of 0x030 returns 0x11111111.
- MemRead held continuously on 0x010 for 8 cycles -> MemReady pulses in cycles 3 and 7, both with data 0xDEADBEEF.
- With WAIT_CYCLES=0: the same held read gives MemReady in cycles 1, 3, 5.
